// File: rtl/writeback_arbiter.sv
// writeback_arbiter: register-file write master; ALU results win the port, long-latency results queue in a FIFO.
// Optional WB_BYPASS_EN macro adds a combinational bypass of the in-flight write onto the decode operands.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_rd,
  input  logic [DW-1:0]                alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [AW-1:0]                lsu_rd,
  input  logic [DW-1:0]                lsu_data,
  output logic                         wre,
  output logic [AW-1:0]                rd,
  output logic [DW-1:0]                di,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  input  logic [AW-1:0]                rs1,
  input  logic [AW-1:0]                rs2,
  input  logic [DW-1:0]                rf_do1,
  input  logic [DW-1:0]                rf_do2,
  output logic [DW-1:0]                fwd_do1,
  output logic [DW-1:0]                fwd_do2
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic aluv;
  logic push;
  logic pop;

  // Register 0 is hardwired; writes to it are dropped at both entry points.
  assign aluv      = alu_valid && (alu_rd != '0);
  assign lsu_ready = (fifo_count != CW'(DEPTH));
  assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign pop       = !aluv && (fifo_count != '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_rd[wr_ptr]   <= lsu_rd;
      mem_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // rd/di keep their last value on idle cycles; only wre drops.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wre <= 1'b0;
      rd  <= '0;
      di  <= '0;
    end else if (aluv) begin
      wre <= 1'b1;
      rd  <= alu_rd;
      di  <= alu_data;
    end else if (pop) begin
      wre <= 1'b1;
      rd  <= mem_rd[rd_ptr];
      di  <= mem_data[rd_ptr];
    end else begin
      wre <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_do1 = (wre && (rd == rs1) && (rs1 != '0)) ? di : rf_do1;
  assign fwd_do2 = (wre && (rd == rs2) && (rs2 != '0)) ? di : rf_do2;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd_do1   = rf_do1;
  assign fwd_do2   = rf_do2;
`endif

endmodule
